// File: rtl/adc_scan_avg.sv
// Round-robin channel sequencer and per-channel decimating averager behind the adc082s021 driver.
// Latency: an average is registered on the clock edge that ends the frame-edge cycle of its last sample.
// Backpressure: none; progress is paced purely by driver frame completions (rising ready).
module adc_scan_avg #(
    parameter int NCHAN   = 2,
    parameter int AVGLOG2 = 4,
    parameter int DW      = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          ready,
    input  logic [DW-1:0] data,
    output logic [2:0]    channel,
    output logic [DW-1:0] avg_data,
    output logic [2:0]    avg_chan,
    output logic          avg_valid
);

    localparam int AW = DW + AVGLOG2;
    localparam int RW = (AVGLOG2 > 0) ? AVGLOG2 : 1;
    localparam logic [RW-1:0] RLAST = RW'((1 << AVGLOG2) - 1);
    localparam logic [2:0]    CLAST = 3'(NCHAN - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t          state;
    logic            ready_q;
    logic [2:0]      data_chan;
    logic [RW-1:0]   round;
    logic [AW-1:0]   acc [0:7];
    logic [AW-1:0]   sum;
    logic            fe;

    function automatic logic [2:0] nxt(input logic [2:0] c);
        return (c == CLAST) ? 3'd0 : c + 3'd1;
    endfunction

    assign fe  = ready & ~ready_q;
    assign sum = acc[data_chan] + AW'(data);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ready_q   <= 1'b1;
            channel   <= 3'd0;
            data_chan <= 3'd0;
            round     <= '0;
            avg_data  <= '0;
            avg_chan  <= 3'd0;
            avg_valid <= 1'b0;
            for (int i = 0; i < 8; i++) acc[i] <= '0;
        end else begin
            ready_q   <= ready;
            avg_valid <= 1'b0;
            if (fe) begin
                if (state != IDLE && !enable) begin
                    // Scan abandoned: any partial round is dropped.
                    state   <= IDLE;
                    channel <= 3'd0;
                    round   <= '0;
                    for (int i = 0; i < 8; i++) acc[i] <= '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (enable) begin
                                state   <= PRIME;
                                channel <= nxt(3'd0);
                            end
                        end
                        PRIME: begin
                            // This frame's data was converted before scanning began.
                            data_chan <= 3'd0;
                            channel   <= nxt(channel);
                            state     <= RUN;
                        end
                        RUN: begin
                            if (round == RLAST) begin
                                avg_data       <= sum[AVGLOG2 +: DW];
                                avg_chan       <= data_chan;
                                avg_valid      <= 1'b1;
                                acc[data_chan] <= '0;
                            end else begin
                                acc[data_chan] <= sum;
                            end
                            if (data_chan == CLAST)
                                round <= (round == RLAST) ? '0 : round + 1'b1;
                            data_chan <= nxt(data_chan);
                            channel   <= nxt(channel);
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_scan_avg.sv
// Bench for adc_scan_avg: frame-level ADC/driver model plus a per-channel sample-averaging reference.
module tb_adc_scan_avg;

    localparam int NCHAN   = 2;
    localparam int AVGLOG2 = 2;
    localparam int DW      = 12;
    localparam int NAVG    = 1 << AVGLOG2;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          ready;
    logic [DW-1:0] data;
    logic [2:0]    channel;
    logic [DW-1:0] avg_data;
    logic [2:0]    avg_chan;
    logic          avg_valid;

    adc_scan_avg #(.NCHAN(NCHAN), .AVGLOG2(AVGLOG2), .DW(DW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ready(ready), .data(data),
        .channel(channel), .avg_data(avg_data), .avg_chan(avg_chan), .avg_valid(avg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic [11:0] dat;
        logic [2:0]  chn;
        logic [2:0]  sel;
        logic [7:0]  stray;
    } fobs_t;

    int checks;
    int fails;

    // ADC model: the driver latches channel in the frame-edge cycle, the ADC converts it one frame later.
    logic [11:0] lut [NCHAN];
    bit          rnd_mode;
    logic [11:0] script [$];
    logic [11:0] r0_val, r1_val;
    int          r0_ch, r1_ch;

    // Reference: per-channel sample sums, an average is due once a channel has NAVG samples.
    bit          scan_on;
    bit          skip;
    int          since_en;
    longint      sums [NCHAN];
    int          cnts [NCHAN];
    logic [11:0] last_d;
    logic [2:0]  last_c;

    function automatic logic [11:0] conv(input logic [2:0] c);
        if (c == 3'd0 && script.size() > 0) return script.pop_front();
        if (rnd_mode) return 12'($urandom_range(0, 4095));
        return lut[int'(c) % NCHAN];
    endfunction

    task automatic clear_sums();
        for (int i = 0; i < NCHAN; i++) begin
            sums[i] = 0;
            cnts[i] = 0;
        end
    endtask

    task automatic model_reset();
        scan_on = 0; skip = 0; since_en = 0;
        clear_sums();
        last_d = '0; last_c = '0;
    endtask

    task automatic model_fe(input logic en, input logic [2:0] lat, output fobs_t exp);
        int c;
        logic [11:0] d;
        d = r0_val; c = r0_ch;
        exp = '0;
        if (!scan_on) begin
            if (en) begin scan_on = 1; skip = 1; since_en = 1; end
        end else if (!en) begin
            scan_on = 0;
            clear_sums();
        end else begin
            since_en++;
            if (skip) skip = 0;
            else if (c >= 0 && c < NCHAN) begin
                sums[c] += d;
                cnts[c]++;
                if (cnts[c] == NAVG) begin
                    last_d = 12'(sums[c] >> AVGLOG2);
                    last_c = 3'(c);
                    exp.vld = 1'b1;
                    sums[c] = 0;
                    cnts[c] = 0;
                end
            end
        end
        exp.dat = last_d;
        exp.chn = last_c;
        exp.sel = scan_on ? 3'(since_en % NCHAN) : 3'd0;
        r0_val = r1_val; r0_ch = r1_ch;
        r1_val = conv(lat); r1_ch = int'(lat);
    endtask

    task automatic run_frame(input logic en, input int len, input int gap, output fobs_t obs, output fobs_t exp);
        logic [2:0] lat;
        @(posedge clk); #1;
        ready = 1'b0; enable = en;
        repeat (len) @(posedge clk);
        #1; ready = 1'b1; data = r0_val;
        @(negedge clk); lat = channel;
        @(posedge clk);
        model_fe(en, lat, exp);
        @(negedge clk);
        obs = '0;
        obs.vld = avg_valid; obs.dat = avg_data; obs.chn = avg_chan; obs.sel = channel;
        repeat (gap) begin
            @(negedge clk);
            if (avg_valid !== 1'b0) obs.stray = obs.stray + 8'd1;
        end
    endtask

    task automatic go_idle();
        fobs_t o, e;
        run_frame(1'b0, 4, 2, o, e);
    endtask

    // Enable from IDLE, then ten frames: strobes only at frames 9 (ch0) and 10 (ch1).
    task automatic scan_round_check(input string name, input logic [11:0] v0, input logic [11:0] v1);
        fobs_t o, e;
        for (int k = 1; k <= 10; k++) begin
            run_frame(1'b1, 4 + k % 3, 2, o, e);
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s_model f%0d: got %h want %h", name, k, o, e);
            end
            checks++;
            if (o.sel !== 3'(k % 2) || o.vld !== (k >= 9) || o.stray !== 8'd0) begin
                fails++;
                $display("FAIL %s_seq f%0d: sel=%0d vld=%0b stray=%0d want sel=%0d vld=%0b stray=0",
                         name, k, o.sel, o.vld, o.stray, k % 2, (k >= 9));
            end
            if (k == 9) begin
                checks++;
                if (o.dat !== v0 || o.chn !== 3'd0) begin
                    fails++;
                    $display("FAIL %s_ch0: got %h/ch%0d want %h/ch0", name, o.dat, o.chn, v0);
                end
            end
            if (k == 10) begin
                checks++;
                if (o.dat !== v1 || o.chn !== 3'd1) begin
                    fails++;
                    $display("FAIL %s_ch1: got %h/ch%0d want %h/ch1", name, o.dat, o.chn, v1);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; ready = 1'b1; data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({channel, avg_data, avg_chan, avg_valid} !== 19'd0) begin
            fails++;
            $display("FAIL reset_state: ch=%0d dat=%h chn=%0d vld=%0b want all 0", channel, avg_data, avg_chan, avg_valid);
        end
        @(posedge clk); #1; reset = 1'b1; enable = 1'b1;
        model_reset();
        // ready already high at release must not look like a frame edge
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (avg_valid !== 1'b0 || channel !== 3'd0) begin
                fails++;
                $display("FAIL reset_release c%0d: vld=%0b ch=%0d want 0/0", i, avg_valid, channel);
            end
        end
        #1; enable = 1'b0;
    endtask

    task automatic test_basic_scan();
        scan_round_check("basic", 12'h100, 12'h200);
    endtask

    task automatic test_prime_discard();
        go_idle();
        r0_val = 12'hABC; r1_val = 12'hABC; r0_ch = -1; r1_ch = -1;
        scan_round_check("prime", 12'h100, 12'h200);
    endtask

    task automatic test_truncation();
        go_idle();
        script = '{12'h001, 12'h002, 12'h003, 12'h003};
        scan_round_check("trunc", 12'h002, 12'h200);
    endtask

    task automatic test_full_scale();
        go_idle();
        lut[0] = 12'hFFF; lut[1] = 12'hFFF;
        scan_round_check("fullscale", 12'hFFF, 12'hFFF);
        lut[0] = 12'h100; lut[1] = 12'h200;
    endtask

    task automatic test_reset_mid();
        go_idle();
        begin
            fobs_t o, e;
            for (int k = 1; k <= 6; k++) run_frame(1'b1, 5, 2, o, e);
        end
        @(posedge clk); #1; ready = 1'b0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({channel, avg_data, avg_chan, avg_valid} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid: ch=%0d dat=%h chn=%0d vld=%0b want all 0", channel, avg_data, avg_chan, avg_valid);
        end
        @(posedge clk); #1; reset = 1'b1;
        model_reset();
        go_idle();
        scan_round_check("after_reset", 12'h100, 12'h200);
    endtask

    task automatic test_enable_drop();
        fobs_t o, e;
        go_idle();
        for (int k = 1; k <= 5; k++) run_frame(1'b1, 6, 2, o, e);
        run_frame(1'b0, 6, 3, o, e);
        checks++;
        if (o !== e || o.vld !== 1'b0 || o.sel !== 3'd0) begin
            fails++;
            $display("FAIL enable_drop: got %h want %h (vld 0, sel 0)", o, e);
        end
        scan_round_check("reenable", 12'h100, 12'h200);
    endtask

    task automatic test_ready_high();
        fobs_t o, e;
        run_frame(1'b1, 5, 40, o, e);
        checks++;
        if (o !== e) begin
            fails++;
            $display("FAIL ready_high: got %h want %h", o, e);
        end
        @(negedge clk);
        checks++;
        if (channel !== e.sel) begin
            fails++;
            $display("FAIL ready_high_sel: ch=%0d want %0d", channel, e.sel);
        end
    endtask

    task automatic test_random();
        fobs_t o, e;
        logic en;
        int nstrobe;
        nstrobe = 0;
        rnd_mode = 1;
        for (int k = 0; k < 80; k++) begin
            en = ($urandom_range(0, 11) != 0);
            run_frame(en, $urandom_range(2, 10), $urandom_range(1, 4), o, e);
            if (e.vld) nstrobe++;
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL random f%0d en=%0b: got %h want %h", k, en, o, e);
            end
        end
        rnd_mode = 0;
        checks++;
        if (nstrobe < 3) begin
            fails++;
            $display("FAIL random_coverage: strobes=%0d want >=3", nstrobe);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; fails = 0;
        reset = 1'b0; enable = 1'b0; ready = 1'b1; data = '0;
        lut[0] = 12'h100; lut[1] = 12'h200;
        rnd_mode = 0;
        r0_val = '0; r1_val = '0; r0_ch = -1; r1_ch = -1;
        model_reset();
        test_reset();
        test_basic_scan();
        test_prime_discard();
        test_truncation();
        test_full_scale();
        test_reset_mid();
        test_enable_drop();
        test_ready_high();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
